// File: rtl/lane_merge_4to1.sv
// Four-lane to one-stream merger: a small FIFO per lane, drained by a round-robin arbiter
// into a registered valid/ready output stage.
module lane_merge_4to1 #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [DATA_W-1:0] in_0,
  input  logic [DATA_W-1:0] in_1,
  input  logic [DATA_W-1:0] in_2,
  input  logic [DATA_W-1:0] in_3,
  input  logic              in_valid_0,
  input  logic              in_valid_1,
  input  logic              in_valid_2,
  input  logic              in_valid_3,
  output logic              in_ready_0,
  output logic              in_ready_1,
  output logic              in_ready_2,
  output logic              in_ready_3,
  output logic [DATA_W-1:0] data_out,
  output logic [1:0]        data_lane,
  output logic              data_valid,
  input  logic              out_ready,
  output logic [3:0]        overflow
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned PtrW  = AddrW + 1;

  logic [DATA_W-1:0] lane_data [4];
  logic [3:0]        lane_valid;
  logic [DATA_W-1:0] mem_q     [4][FIFO_DEPTH];
  logic [PtrW-1:0]   wr_ptr_q  [4];
  logic [PtrW-1:0]   rd_ptr_q  [4];
  logic [3:0]        full, empty, push, pop;

  logic [DATA_W-1:0] data_q;
  logic [1:0]        lane_q, last_q;
  logic              valid_q;
  logic [3:0]        overflow_q;

  logic              load_en, grant_vld;
  logic [1:0]        grant_idx, cand;

  assign lane_data[0] = in_0;
  assign lane_data[1] = in_1;
  assign lane_data[2] = in_2;
  assign lane_data[3] = in_3;
  assign lane_valid   = {in_valid_3, in_valid_2, in_valid_1, in_valid_0};

  always_comb begin
    for (int i = 0; i < 4; i++) begin
      full[i]  = (wr_ptr_q[i][AddrW] != rd_ptr_q[i][AddrW]) &&
                 (wr_ptr_q[i][AddrW-1:0] == rd_ptr_q[i][AddrW-1:0]);
      empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
    end
  end

  // Full is pre-edge state, so a same-cycle pop never makes room for a push.
  assign push    = lane_valid & ~full;
  assign load_en = ~valid_q | out_ready;

  // Round-robin search starting one past the last granted lane.
  always_comb begin
    grant_vld = 1'b0;
    grant_idx = last_q;
    cand      = '0;
    for (int i = 0; i < 4; i++) begin
      cand = last_q + 2'(i + 1);
      if (!grant_vld && !empty[cand]) begin
        grant_vld = 1'b1;
        grant_idx = cand;
      end
    end
  end

  assign pop = (load_en && grant_vld) ? (4'b0001 << grant_idx) : 4'b0000;

  always_ff @(posedge clk_in) begin
    for (int i = 0; i < 4; i++) begin
      if (push[i]) begin
        mem_q[i][wr_ptr_q[i][AddrW-1:0]] <= lane_data[i];
      end
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      for (int i = 0; i < 4; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
      overflow_q <= '0;
      data_q     <= '0;
      lane_q     <= '0;
      valid_q    <= 1'b0;
      last_q     <= 2'd3;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (push[i]) wr_ptr_q[i] <= wr_ptr_q[i] + PtrW'(1);
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PtrW'(1);
      end
      overflow_q <= overflow_q | (lane_valid & full);
      if (load_en) begin
        valid_q <= grant_vld;
        if (grant_vld) begin
          data_q <= mem_q[grant_idx][rd_ptr_q[grant_idx][AddrW-1:0]];
          lane_q <= grant_idx;
          last_q <= grant_idx;
        end
      end
    end
  end

  assign in_ready_0 = ~full[0];
  assign in_ready_1 = ~full[1];
  assign in_ready_2 = ~full[2];
  assign in_ready_3 = ~full[3];
  assign data_out   = data_q;
  assign data_lane  = lane_q;
  assign data_valid = valid_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_lane_merge_4to1.sv
// Bench for lane_merge_4to1: directed scenarios plus random traffic against a queue-based model.
module tb_lane_merge_4to1;

  localparam int unsigned Depth = 4;

  logic       clk_in = 1'b0;
  logic       reset_in;
  logic [7:0] din [4];
  logic [3:0] vin;
  logic       out_ready;
  logic       in_ready_0, in_ready_1, in_ready_2, in_ready_3;
  logic [7:0] data_out;
  logic [1:0] data_lane;
  logic       data_valid;
  logic [3:0] overflow;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model state
  logic [7:0] mq [4][$];
  logic       m_valid;
  logic [7:0] m_data;
  logic [1:0] m_lane;
  int         m_last;
  logic [3:0] m_ovf;

  lane_merge_4to1 #(.DATA_W(8), .FIFO_DEPTH(Depth)) dut (
    .clk_in     (clk_in),
    .reset_in   (reset_in),
    .in_0       (din[0]),
    .in_1       (din[1]),
    .in_2       (din[2]),
    .in_3       (din[3]),
    .in_valid_0 (vin[0]),
    .in_valid_1 (vin[1]),
    .in_valid_2 (vin[2]),
    .in_valid_3 (vin[3]),
    .in_ready_0 (in_ready_0),
    .in_ready_1 (in_ready_1),
    .in_ready_2 (in_ready_2),
    .in_ready_3 (in_ready_3),
    .data_out   (data_out),
    .data_lane  (data_lane),
    .data_valid (data_valid),
    .out_ready  (out_ready),
    .overflow   (overflow)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mq[i].delete();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_lane  = 2'd0;
    m_last  = 3;
    m_ovf   = 4'h0;
  endtask

  // One clock edge of the merger's contract, using pre-edge queue occupancy.
  task automatic model_edge();
    int  sz [4];
    bit  found;
    int  l;
    if (reset_in) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 4; i++) sz[i] = mq[i].size();
    if (!m_valid || out_ready) begin
      found = 0;
      for (int k = 1; k <= 4; k++) begin
        l = (m_last + k) % 4;
        if (!found && sz[l] > 0) begin
          found  = 1;
          m_data = mq[l].pop_front();
          m_lane = 2'(l);
          m_last = l;
        end
      end
      m_valid = found;
    end
    for (int i = 0; i < 4; i++) begin
      if (vin[i]) begin
        if (sz[i] < Depth) mq[i].push_back(din[i]);
        else m_ovf[i] = 1'b1;
      end
    end
  endtask

  task automatic check_all(input string tag);
    logic [3:0] rdy;
    rdy = {in_ready_3, in_ready_2, in_ready_1, in_ready_0};
    chk({tag, ".data_valid"}, 32'(data_valid), 32'(m_valid));
    chk({tag, ".data_out"}, 32'(data_out), 32'(m_data));
    chk({tag, ".data_lane"}, 32'(data_lane), 32'(m_lane));
    chk({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
    for (int i = 0; i < 4; i++)
      chk($sformatf("%s.in_ready_%0d", tag, i), 32'(rdy[i]), 32'(mq[i].size() < Depth));
  endtask

  task automatic cycle(input string tag);
    @(posedge clk_in);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    vin = 4'h0;
    for (int i = 0; i < 4; i++) din[i] = 8'h00;
  endtask

  task automatic do_reset();
    reset_in = 1'b1;
    idle();
    cycle("rst");
    reset_in = 1'b0;
  endtask

  initial begin
    reset_in  = 1'b1;
    out_ready = 1'b1;
    idle();
    model_reset();

    // 1: reset held 110 ns
    for (int t = 0; t < 5; t++) begin
      #21;
      chk("t1.data_valid", 32'(data_valid), 32'h0);
      chk("t1.overflow", 32'(overflow), 32'h0);
      chk("t1.in_ready", 32'({in_ready_3, in_ready_2, in_ready_1, in_ready_0}), 32'hf);
    end
    #5;
    reset_in = 1'b0;

    // 2: single byte on lane 0
    din[0] = 8'hA5; vin = 4'b0001;
    cycle("t2a");
    chk("t2.lat0", 32'(data_valid), 32'h0);
    idle();
    cycle("t2b");
    chk("t2.data", 32'(data_out), 32'hA5);
    chk("t2.lane", 32'(data_lane), 32'h0);
    chk("t2.valid", 32'(data_valid), 32'h1);
    cycle("t2c");
    chk("t2.once", 32'(data_valid), 32'h0);

    // 3: all four lanes at once drain in lane order
    do_reset();
    for (int i = 0; i < 4; i++) din[i] = 8'h10 + 8'(i);
    vin = 4'hf;
    cycle("t3p");
    idle();
    for (int k = 0; k < 4; k++) begin
      cycle("t3");
      chk("t3.data", 32'(data_out), 32'h10 + 32'(k));
      chk("t3.lane", 32'(data_lane), 32'(k));
    end
    cycle("t3e");

    // 4: lanes 0 and 2 streaming
    do_reset();
    for (int k = 0; k < 6; k++) begin
      din[0] = 8'h40 + 8'(k); din[2] = 8'h80 + 8'(k); vin = 4'b0101;
      cycle("t4");
      if (k > 0) chk("t4.lane", 32'(data_lane), (k % 2 == 1) ? 32'h0 : 32'h2);
    end
    idle();
    chk("t4.ovf", 32'(overflow), 32'h0);
    for (int k = 0; k < 8; k++) cycle("t4d");

    // 5: lane 1 fills with output stalled
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      din[1] = 8'(k); vin = 4'b0010;
      cycle("t5f");
    end
    idle();
    chk("t5.ovf", 32'(overflow), 32'h2);
    chk("t5.rdy1", 32'(in_ready_1), 32'h0);
    chk("t5.hold", 32'(data_out), 32'h01);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      cycle("t5d");
      chk("t5.data", 32'(data_out), 32'(k));
    end
    cycle("t5e");
    chk("t5.empty", 32'(data_valid), 32'h0);

    // Random traffic, light then heavy, with random back-pressure
    do_reset();
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < 4; i++) begin
        din[i] = 8'($urandom);
        vin[i] = (k < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 1) == 1);
      end
      out_ready = ($urandom_range(0, 3) != 0);
      cycle("rnd");
    end
    idle();
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) cycle("rndd");

    // 6: asynchronous reset with lane 3 holding data
    do_reset();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      din[3] = 8'hC0 + 8'(k); vin = 4'b1000;
      cycle("t6f");
    end
    idle();
    chk("t6.pre", 32'(data_valid), 32'h1);
    #2;
    reset_in = 1'b1;
    model_reset();
    #1;
    chk("t6.async_valid", 32'(data_valid), 32'h0);
    chk("t6.async_data", 32'(data_out), 32'h0);
    check_all("t6a");
    cycle("t6r");
    reset_in  = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cycle("t6p");
      chk("t6.stale", 32'(data_valid), 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
